flip_select_controller: RTL and testbench
=========================================

# flip_select_controller

Sequencer for the variable-flip selection datapath in the WalkSAT core. It takes one broken clause (NSAT variable indices plus per-literal valid bits) and, for each literal in turn, fetches that variable's occurrence row from occurrence memory. It then drives the flip selector's write-enable code to latch each break value and finally commands heuristic selection. It returns the chosen variable index to the flip engine through a valid/ready handshake.

## Interface
- NSAT, 3, literals per clause; only 3 is supported, and any other value triggers an elaboration `$error`.
- VAR_W, 12, variable index width.
- clk in 1: sole clock.
- reset in 1: synchronous, active-high.
- start_i in 1: request pulse; sampled only in IDLE.
- clause_vars_i in NSAT*VAR_W: literal k's variable is in bits [k*VAR_W +: VAR_W]; latched on an accepted start.
- lit_valid_i in NSAT: per-literal valid bits; latched on an accepted start.
- busy_o out 1: high in every state except IDLE.
- occ_rd_en_o out 1: one-cycle read strobe to occurrence memory.
- occ_rd_addr_o out VAR_W: variable index for the read; held until the next strobe.
- occ_rd_valid_i in 1: memory data valid. The memory holds the data stable on the selector inputs until its next occ_rd_en_o.
- wren_o out 2: selector control code. 00 = idle, 01 = latch row 0, 10 = latch row 1, 11 = select.
- bv_valid_o out NSAT: latched lit_valid_i while wren_o == 11, else 0.
- sel_i in 2: selector's registered selected index.
- flip_var_o out VAR_W: chosen variable index.
- flip_valid_o out 1: result valid.
- flip_ready_i in 1: consumer accepts the result.
- sel_err_o out 1: one-cycle pulse when sel_i > NSAT-1 at capture.

## Operation
- States: IDLE, REQ, WAIT, WRITE, SEL, CAPTURE, OUT. Literal counter k is 2 bits.
- IDLE
  - On start_i: latch the clause, set k=0, go to REQ.
- REQ
  - occ_rd_en_o=1 and occ_rd_addr_o=var[k], then go to WAIT.
- WAIT
  - Stay until occ_rd_valid_i is high.
  - When it is high: go to WRITE if k<NSAT-1, otherwise go to SEL.
- WRITE
  - wren_o = one-hot(k), then k++ and go to REQ.
- SEL
  - wren_o=11 and bv_valid_o = latched valid bits, then go to CAPTURE.
- CAPTURE
  - sel_i now reflects this selection.
  - If sel_i ≤ NSAT-1: flip_var_o = var[sel_i].
  - Otherwise: flip_var_o = 0 and sel_err_o pulses.
  - Go to OUT.
- OUT
  - flip_valid_o=1, with flip_var_o held stable.
  - On flip_ready_i: go to IDLE. Ready asserted in the same cycle valid first rises counts as acceptance.
- start_i while busy_o=1 is ignored; it is not queued.
- occ_rd_valid_i outside WAIT is ignored.
- A new start is accepted no earlier than the cycle after the handshake completes.
- reset in any state, including mid-fetch or in OUT:
  - next state is IDLE;
  - all outputs return to reset values;
  - any in-flight memory response is dropped by the WAIT-only rule.
- Reset values: busy_o=0, occ_rd_en_o=0, occ_rd_addr_o=0, wren_o=00, bv_valid_o=0, flip_var_o=0, flip_valid_o=0, sel_err_o=0.
- All outputs are registered or decoded directly from the state register. There are no combinational paths from inputs to outputs.

## Timing
- Memory latency is L ≥ 1: occ_rd_valid_i rises L cycles after occ_rd_en_o.
- Start accepted at cycle s:
  - literal k's REQ occurs at s+1+k(L+2);
  - SEL occurs at s+2(L+2)+L+2;
  - flip_valid_o first rises at s+3L+8 (s+11 for L=1).
- wren_o is asserted exactly one cycle per WRITE or SEL. It never holds 11 for more than one cycle.
- Back-to-back operation: IDLE → REQ adds one cycle after acceptance.

## Configuration
- FSC_SKIP_INVALID_EN defined: a literal with lit_valid_i[k]=0 gets no occurrence fetch.
  - For k<NSAT-1, REQ goes straight to REQ with k++. There is no strobe and no wren, costing 1 cycle.
  - For k=NSAT-1, REQ goes straight to SEL.
  - The selector ignores the stale data because its bv_valid bit is 0.
- Undefined: every literal is fetched regardless of its valid bit, giving fixed latency 3L+8.

## Test plan
- Reset check: reset for 2 cycles with start_i=1 → all outputs at reset values and busy_o=0.
- Nominal run: L=1, vars {5,9,17}, valid 111, sel_i=01 at CAPTURE → wren sequence 01, 10, 11 at cycles s+3, s+6, s+9; flip_var_o=9; flip_valid_o rises at s+11.
- Long latency with backpressure: L=4 and flip_ready_i held low for 5 cycles → flip_valid_o rises at s+20 and holds with flip_var_o stable for 5 cycles; exactly one acceptance.
- Invalid selection: sel_i=11 at CAPTURE → sel_err_o pulses once and flip_var_o=0.
- Abort and busy start: reset asserted in WAIT of literal 1 with a late occ_rd_valid_i → no wren_o pulse, IDLE next cycle; start_i pulsed while busy → ignored.
- Skip mode, FSC_SKIP_INVALID_EN set: valid 101, L=1 → exactly two occ_rd_en_o pulses; wren sequence 01, 11; bv_valid_o=101 during SEL.

Source files
------------

// File: rtl/flip_select_controller.sv
// flip_select_controller: sequences occurrence fetches, selector write-enables and flip-variable capture for one broken clause.
// Optional feature macro: FSC_SKIP_INVALID_EN (skip occurrence fetches for invalid literals).
module flip_select_controller #(
    parameter int NSAT  = 3,
    parameter int VAR_W = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic [NSAT*VAR_W-1:0]   clause_vars_i,
    input  logic [NSAT-1:0]         lit_valid_i,
    output logic                    busy_o,
    output logic                    occ_rd_en_o,
    output logic [VAR_W-1:0]        occ_rd_addr_o,
    input  logic                    occ_rd_valid_i,
    output logic [1:0]              wren_o,
    output logic [NSAT-1:0]         bv_valid_o,
    input  logic [1:0]              sel_i,
    output logic [VAR_W-1:0]        flip_var_o,
    output logic                    flip_valid_o,
    input  logic                    flip_ready_i,
    output logic                    sel_err_o
);
    generate
        if (NSAT != 3) begin : g_nsat_check
            $error("flip_select_controller supports only NSAT == 3");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_SEL, S_CAPTURE, S_OUT} state_t;

    localparam logic [1:0] LAST = 2'(NSAT - 1);

    state_t             r_state;
    logic [1:0]         r_k;
    logic [VAR_W-1:0]   r_vars [NSAT];
    logic [NSAT-1:0]    r_valid;
    logic [VAR_W-1:0]   r_addr;
    logic [VAR_W-1:0]   r_flip_var;
    logic               r_sel_err;
    logic               w_skip;
    logic               w_rd_en;
    logic [VAR_W-1:0]   w_addr;

`ifdef FSC_SKIP_INVALID_EN
    assign w_skip = !r_valid[r_k];
`else
    assign w_skip = 1'b0;
`endif

    assign w_addr        = r_vars[r_k];
    assign w_rd_en       = (r_state == S_REQ) && !w_skip;
    assign busy_o        = (r_state != S_IDLE);
    assign occ_rd_en_o   = w_rd_en;
    assign occ_rd_addr_o = w_rd_en ? w_addr : r_addr;
    assign wren_o        = (r_state == S_SEL) ? 2'b11 :
                           (r_state == S_WRITE) ? ((r_k == 2'd0) ? 2'b01 : 2'b10) : 2'b00;
    assign bv_valid_o    = (r_state == S_SEL) ? r_valid : '0;
    assign flip_var_o    = r_flip_var;
    assign flip_valid_o  = (r_state == S_OUT);
    assign sel_err_o     = r_sel_err;

    // Main sequencer: walks literals, fetches rows, commands selection, then holds the result until accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_k        <= 2'd0;
            r_valid    <= '0;
            r_addr     <= '0;
            r_flip_var <= '0;
            r_sel_err  <= 1'b0;
            for (int i = 0; i < NSAT; i++) r_vars[i] <= '0;
        end else begin
            r_sel_err <= 1'b0;
            if (w_rd_en) r_addr <= w_addr;
            case (r_state)
                S_IDLE: if (start_i) begin
                    for (int i = 0; i < NSAT; i++) r_vars[i] <= clause_vars_i[i*VAR_W +: VAR_W];
                    r_valid <= lit_valid_i;
                    r_k     <= 2'd0;
                    r_state <= S_REQ;
                end
                S_REQ: if (!w_skip) r_state <= S_WAIT;
                    else if (r_k == LAST) r_state <= S_SEL;
                    else r_k <= r_k + 2'd1;
                S_WAIT: if (occ_rd_valid_i) r_state <= (r_k < LAST) ? S_WRITE : S_SEL;
                S_WRITE: begin
                    r_k     <= r_k + 2'd1;
                    r_state <= S_REQ;
                end
                S_SEL: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_flip_var <= (sel_i <= LAST) ? r_vars[sel_i] : '0;
                    r_sel_err  <= (sel_i > LAST);
                    r_state    <= S_OUT;
                end
                S_OUT: if (flip_ready_i) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flip_select_controller.sv
// tb_flip_select_controller: directed and randomized checks of the flip-select sequencer against a schedule model.
module tb_flip_select_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [35:0] clause_vars_i;
    logic [2:0]  lit_valid_i;
    logic        busy_o;
    logic        occ_rd_en_o;
    logic [11:0] occ_rd_addr_o;
    logic        occ_rd_valid_i;
    logic [1:0]  wren_o;
    logic [2:0]  bv_valid_o;
    logic [1:0]  sel_i;
    logic [11:0] flip_var_o;
    logic        flip_valid_o;
    logic        flip_ready_i;
    logic        sel_err_o;
    int          checks = 0;
    int          errors = 0;

`ifdef FSC_SKIP_INVALID_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    flip_select_controller #(.NSAT(3), .VAR_W(12)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .clause_vars_i(clause_vars_i),
        .lit_valid_i(lit_valid_i), .busy_o(busy_o), .occ_rd_en_o(occ_rd_en_o),
        .occ_rd_addr_o(occ_rd_addr_o), .occ_rd_valid_i(occ_rd_valid_i), .wren_o(wren_o),
        .bv_valid_o(bv_valid_o), .sel_i(sel_i), .flip_var_o(flip_var_o),
        .flip_valid_o(flip_valid_o), .flip_ready_i(flip_ready_i), .sel_err_o(sel_err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_rden"}, occ_rd_en_o, 0);
        chk({tag, "_wren"}, wren_o, 0);
        chk({tag, "_bv"}, bv_valid_o, 0);
        chk({tag, "_fvalid"}, flip_valid_o, 0);
        chk({tag, "_selerr"}, sel_err_o, 0);
    endtask

    // One clause transaction; called in an IDLE cycle. Expected schedule is built from the latency rules.
    task automatic run_txn(input logic [35:0] vars, input logic [2:0] vld, input int lat,
                           input logic [1:0] sel, input int rdly);
        logic [1:0]  ew [64];
        logic        ee [64];
        logic [11:0] ea [64];
        logic [11:0] exp_var;
        int t, selc, acc, pend;
        for (int i = 0; i < 64; i++) begin ew[i] = 2'b00; ee[i] = 1'b0; ea[i] = '0; end
        t = 1;
        selc = 0;
        for (int k = 0; k < 3; k++) begin
            if (SKIP && !vld[k]) begin
                if (k < 2) t += 1; else selc = t + 1;
            end else begin
                ee[t] = 1'b1;
                ea[t] = vars[k*12 +: 12];
                if (k < 2) begin
                    ew[t+lat+1] = (k == 0) ? 2'b01 : 2'b10;
                    t += lat + 2;
                end else selc = t + lat + 1;
            end
        end
        ew[selc] = 2'b11;
        acc = selc + 2 + rdly;
        exp_var = (sel == 2'd3) ? 12'd0 : vars[sel*12 +: 12];
        pend = -1;
        start_i = 1'b1;
        clause_vars_i = vars;
        lit_valid_i = vld;
        for (int o = 1; o <= acc + 1; o++) begin
            tick();
            start_i = (o == 3) || (o == acc);
            clause_vars_i = 36'($urandom);
            lit_valid_i = 3'($urandom);
            chk("busy", busy_o, o <= acc);
            chk("rd_en", occ_rd_en_o, ee[o]);
            if (ee[o]) chk("rd_addr", occ_rd_addr_o, ea[o]);
            chk("wren", wren_o, ew[o]);
            chk("bv_valid", bv_valid_o, (o == selc) ? vld : 3'b000);
            chk("sel_err", sel_err_o, (o == selc + 2) && (sel == 2'd3));
            chk("flip_valid", flip_valid_o, (o >= selc + 2) && (o <= acc));
            if (o >= selc + 2 && o <= acc) chk("flip_var", flip_var_o, exp_var);
            occ_rd_valid_i = (o == pend) || (o > selc && o <= acc && $urandom_range(1) == 1);
            if (occ_rd_en_o) pend = o + lat;
            sel_i = (o == selc + 1) ? sel : 2'($urandom);
            flip_ready_i = (o >= selc + 2 + rdly) ? 1'b1 : 1'($urandom_range(1) & (o < selc + 2));
        end
        start_i = 1'b0;
        flip_ready_i = 1'b0;
        occ_rd_valid_i = 1'b0;
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        start_i = 1'b1;
        clause_vars_i = {12'd17, 12'd9, 12'd5};
        lit_valid_i = 3'b111;
        occ_rd_valid_i = 1'b0;
        sel_i = 2'd0;
        flip_ready_i = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_addr", occ_rd_addr_o, 0);
        chk("reset_var", flip_var_o, 0);
        reset = 1'b0;
        start_i = 1'b0;
        tick();
        chk_idle("post_reset");
        run_txn({12'd17, 12'd9, 12'd5}, 3'b111, 1, 2'd1, 0);
        run_txn({12'd300, 12'd4000, 12'd77}, 3'b111, 4, 2'd2, 5);
        run_txn({12'd1, 12'd2, 12'd3}, 3'b111, 2, 2'd3, 1);
        run_txn({12'd11, 12'd22, 12'd33}, 3'b101, 1, 2'd0, 0);
        // Abort in the WAIT of literal 1 with a late memory response afterwards
        lat = 3;
        start_i = 1'b1;
        clause_vars_i = {12'd8, 12'd7, 12'd6};
        lit_valid_i = 3'b111;
        for (int o = 1; o <= lat + 5; o++) begin
            tick();
            start_i = 1'b0;
            occ_rd_valid_i = (o == lat + 1);
        end
        chk("abort_wait_rden", occ_rd_en_o, 0);
        chk("abort_wait_busy", busy_o, 1);
        reset = 1'b1;
        occ_rd_valid_i = 1'b0;
        tick();
        reset = 1'b0;
        chk_idle("abort_reset");
        occ_rd_valid_i = 1'b1;
        tick();
        chk_idle("abort_late1");
        occ_rd_valid_i = 1'b0;
        tick();
        chk_idle("abort_late2");
        for (int n = 0; n < 10; n++)
            run_txn(36'($urandom), 3'($urandom), int'($urandom_range(6, 1)),
                    2'($urandom), int'($urandom_range(4, 0)));
        tick();
        chk_idle("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
